// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction loader: FSM states,
// error codes and stream header size.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

    localparam int HDR_LEN = 2;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Assembles four accepted stream bytes (LSB first) into a 32-bit word and
// flags the acceptance of the final byte.
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0]  idx;
    logic [23:0] low;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= 2'd0;
            low <= 24'd0;
        end else if (clear) begin
            idx <= 2'd0;
            low <= 24'd0;
        end else if (accept) begin
            idx <= idx + 2'd1;
            case (idx)
                2'd0:    low[7:0]   <= byte_data;
                2'd1:    low[15:8]  <= byte_data;
                2'd2:    low[23:16] <= byte_data;
                default: low        <= low;
            endcase
        end
    end

    // Byte 3 is taken straight from the input so the word is complete on its accepting edge.
    assign word      = {byte_data, low};
    assign word_done = accept && (idx == 2'd3);

endmodule

// File: rtl/inst_loader.sv
// Boot-time instruction loader: receives a length-prefixed, XOR-checked byte
// image and writes it into instruction memory, holding the core in reset until done.
module inst_loader
    import loader_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  IN_DATA,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic        RELOAD,
    output logic        IM_WE,
    output logic [31:0] IM_ADDR,
    output logic [31:0] IM_WD,
    output logic        CORE_RST,
    output logic        LOAD_DONE,
    output logic        LOAD_ERR,
    output logic [1:0]  ERR_CODE,
    output logic [15:0] WORDS_LOADED,
    output logic [2:0]  dbg_state
);

    // valid/ready: a byte moves on a rising edge only when IN_VALID and IN_READY
    // are both high; the source must hold IN_DATA stable while IN_READY is low.

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t      state;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [7:0]  csum;
    logic        xfer;
    logic        pack_clear;
    logic        pack_accept;
    logic [31:0] word;
    logic        word_done;

    assign IN_READY    = (state == LEN_LO) || (state == LEN_HI) ||
                         (state == DATA)   || (state == CSUM);
    assign xfer        = IN_VALID && IN_READY;
    assign pack_accept = xfer && (state == DATA);
    assign pack_clear  = RELOAD && ((state == DONE) || (state == ERROR));
    assign dbg_state   = state;

    byte_packer u_packer (
        .clk       (CLK),
        .rst_n     (RST),
        .clear     (pack_clear),
        .accept    (pack_accept),
        .byte_data (IN_DATA),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            len_lo       <= 8'd0;
            len          <= 16'd0;
            csum         <= 8'd0;
            IM_WE        <= 1'b0;
            IM_ADDR      <= 32'd0;
            IM_WD        <= 32'd0;
            WORDS_LOADED <= 16'd0;
            CORE_RST     <= 1'b0;
            LOAD_DONE    <= 1'b0;
            LOAD_ERR     <= 1'b0;
            ERR_CODE     <= ERR_NONE;
        end else begin
            IM_WE <= 1'b0;
            if (word_done) begin
                IM_WE        <= 1'b1;
                IM_WD        <= word;
                IM_ADDR      <= BASE_ADDR + {14'd0, WORDS_LOADED, 2'b00};
                WORDS_LOADED <= WORDS_LOADED + 16'd1;
            end

            case (state)
                IDLE: begin
                    csum  <= 8'd0;
                    state <= LEN_LO;
                end
                LEN_LO: if (xfer) begin
                    len_lo <= IN_DATA;
                    state  <= LEN_HI;
                end
                LEN_HI: if (xfer) begin
                    len <= {IN_DATA, len_lo};
                    if ({1'b0, IN_DATA, len_lo} > DEPTH_W) begin
                        state    <= ERROR;
                        LOAD_ERR <= 1'b1;
                        ERR_CODE <= ERR_LEN;
                    end else if ({IN_DATA, len_lo} == 16'd0) begin
                        state <= CSUM;
                    end else begin
                        state <= DATA;
                    end
                end
                DATA: if (xfer) begin
                    csum <= csum ^ IN_DATA;
                    if (word_done && (WORDS_LOADED + 16'd1 == len))
                        state <= CSUM;
                end
                CSUM: if (xfer) begin
                    if (IN_DATA == csum) begin
                        state     <= DONE;
                        LOAD_DONE <= 1'b1;
                        CORE_RST  <= 1'b1;
                    end else begin
                        state    <= ERROR;
                        LOAD_ERR <= 1'b1;
                        ERR_CODE <= ERR_CSUM;
                    end
                end
                DONE, ERROR: if (RELOAD) begin
                    state        <= LEN_LO;
                    csum         <= 8'd0;
                    WORDS_LOADED <= 16'd0;
                    CORE_RST     <= 1'b0;
                    LOAD_DONE    <= 1'b0;
                    LOAD_ERR     <= 1'b0;
                    ERR_CODE     <= ERR_NONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
